// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution layer sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int EN_VALID = 0;
  localparam int EN_FIRST = 1;
  localparam int EN_LAST  = 2;

  localparam int DEF_N  = 32;
  localparam int DEF_Q  = 15;
  localparam int DEF_E8 = 10;

  // Number of valid kernel placements along one image dimension.
  function automatic int out_dim(input int img, input int ksz);
    return img - ksz + 1;
  endfunction

endpackage

// File: rtl/conv_win_cnt.sv
// Nested window walker: kernel row k inside column c inside row r, plus a
// flat output-position index. Advances one kernel row per adv_i.
module conv_win_cnt #(
  parameter int K  = 3,
  parameter int OW = 6,
  parameter int OH = 6,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [CW-1:0] k_o,
  output logic [CW-1:0] c_o,
  output logic [CW-1:0] r_o,
  output logic [CW-1:0] pos_o,
  output logic          k_wrap_o,
  output logic          c_wrap_o,
  output logic          last_o
);

  logic [CW-1:0] k_q, k_d;
  logic [CW-1:0] c_q, c_d;
  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] pos_q, pos_d;
  logic          k_wrap, c_wrap, last;

  assign k_wrap = (k_q == CW'(K - 1));
  assign c_wrap = (c_q == CW'(OW - 1));
  assign last   = k_wrap && c_wrap && (r_q == CW'(OH - 1));

  always_comb begin
    k_d   = k_q;
    c_d   = c_q;
    r_d   = r_q;
    pos_d = pos_q;
    if (clr_i) begin
      k_d   = '0;
      c_d   = '0;
      r_d   = '0;
      pos_d = '0;
    end else if (adv_i) begin
      if (!k_wrap) begin
        k_d = k_q + CW'(1);
      end else begin
        k_d   = '0;
        pos_d = pos_q + CW'(1);
        if (!c_wrap) begin
          c_d = c_q + CW'(1);
        end else begin
          c_d = '0;
          r_d = r_q + CW'(1);
        end
        // The final advance leaves the walker parked at the origin.
        if (last) begin
          r_d   = '0;
          pos_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      c_q   <= '0;
      r_q   <= '0;
      pos_q <= '0;
    end else begin
      k_q   <= k_d;
      c_q   <= c_d;
      r_q   <= r_d;
      pos_q <= pos_d;
    end
  end

  assign k_o      = k_q;
  assign c_o      = c_q;
  assign r_o      = r_q;
  assign pos_o    = pos_q;
  assign k_wrap_o = k_wrap;
  assign c_wrap_o = c_wrap;
  assign last_o   = last;

endmodule

// File: rtl/conv_layer_ctrl.sv
// Convolution layer sequencer: issues one kernel row per cycle to the RAMs and
// drives the PE enable vector. Optional macro CONV_CTRL_STALL_CNT_EN adds stall_cnt.
module conv_layer_ctrl
  import conv_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int Q      = DEF_Q,
  parameter int E8     = DEF_E8,
  parameter int K      = 3,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16,
  parameter int X_BASE = 0,
  parameter int W_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pe_ready,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              rd_en,
  output logic [E8-1:0]     en,
  output logic [ADDR_W-1:0] pos_idx,
  output logic              busy,
  output logic              done
`ifdef CONV_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int OW = out_dim(IMG_W, K);
  localparam int OH = out_dim(IMG_H, K);

  if (IMG_W < K || IMG_H < K) begin : g_bad_geometry
    $error("conv_layer_ctrl: image must be at least KxK");
  end
  if (E8 < 3) begin : g_bad_e8
    $error("conv_layer_ctrl: E8 must be >= 3");
  end
  if (N < 1 || Q >= N) begin : g_bad_fmt
    $error("conv_layer_ctrl: Q must be smaller than N");
  end

  state_e              state_q;
  logic                busy_q, done_q;
  logic [E8-1:0]       en_q, en_d;
  logic [ADDR_W-1:0]   pos_idx_q;
  logic                issue, accept;
  logic [ADDR_W-1:0]   k_cnt, c_cnt, r_cnt, pos_cnt;
  logic                k_wrap, c_wrap, last_row;

  assign accept = (state_q == ST_IDLE) && start;
  assign issue  = (state_q == ST_RUN) && pe_ready;

  conv_win_cnt #(
    .K  (K),
    .OW (OW),
    .OH (OH),
    .CW (ADDR_W)
  ) u_win_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (accept),
    .adv_i    (issue),
    .k_o      (k_cnt),
    .c_o      (c_cnt),
    .r_o      (r_cnt),
    .pos_o    (pos_cnt),
    .k_wrap_o (k_wrap),
    .c_wrap_o (c_wrap),
    .last_o   (last_row)
  );

  // Addresses follow the registered counters, so they hold through stalls.
  assign x_addr = ADDR_W'(X_BASE) + (r_cnt + k_cnt) * ADDR_W'(IMG_W) + c_cnt;
  assign w_addr = ADDR_W'(W_BASE) + k_cnt * ADDR_W'(K);
  assign rd_en  = issue;

  always_comb begin
    en_d           = '0;
    en_d[EN_VALID] = issue;
    en_d[EN_FIRST] = issue && (k_cnt == '0);
    en_d[EN_LAST]  = issue && k_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= '0;
      pos_idx_q <= '0;
    end else begin
      // en and pos_idx trail the issue by one cycle to line up with RAM data.
      en_q <= en_d;
      if (issue) begin
        pos_idx_q <= pos_cnt;
      end
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (issue && last_row) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign en      = en_q;
  assign pos_idx = pos_idx_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef CONV_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (accept) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ST_RUN) && !pe_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  // c_wrap is folded into last_row inside the walker; kept for observability.
  logic unused_ok;
  assign unused_ok = c_wrap;

endmodule
